// File: rtl/dm_access_arbiter_if.sv
// Bundles the CPU M-stage port, the DMA/debug port and the data-memory port.
// Latency: none; this is wiring only.
// Backpressure: none; the arbiter stalls the CPU through cpu_stall.
//   slave  : the arbiter's view (requests in, grants and memory drive out)
//   master : the requesters' and memory's view (the reverse)
interface dm_access_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_byte;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic        DM_writeMem_EN;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_dataIN;
    logic        M_isByte;
    logic [31:0] M_PC;
    logic [31:0] M_dataOUT;

    modport slave (
        input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, cpu_pc,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output DM_writeMem_EN, DM_ADDR, DM_dataIN, M_isByte, M_PC,
        input  M_dataOUT
    );

    modport master (
        output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, cpu_pc,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  DM_writeMem_EN, DM_ADDR, DM_dataIN, M_isByte, M_PC,
        output M_dataOUT
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the M stage and a DMA/debug port.
// Latency: grant, stall and memory mux are combinational; DMA read data returns 1 cycle after grant.
// Backpressure: the CPU is stalled (must hold its request) whenever the DMA is granted; the DMA waits at most STARVE_LIMIT cycles.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : CPU request/stall, DMA request/grant/read return, memory drive/read data
module dm_access_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter int          BURST_MAX    = 8,
    parameter logic [31:0] DMA_PC_TAG   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dm_access_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    typedef enum logic {S_CPU, S_DMA_LOCK} state_t;

    state_t     state, stateNext;
    logic [3:0] waitCnt, waitCntNext;
    logic [3:0] burstCnt, burstCntNext;
    logic       starveHit, burstHold, dmaGnt, cpuGnt;

    // CPU has priority unless the DMA has waited long enough or holds a burst.
    assign starveHit = (waitCnt == STARVE_LIM);
    assign burstHold = (state == S_DMA_LOCK) && bus.dma_lock && (burstCnt < BURST_LIM);
    assign dmaGnt    = !reset && bus.dma_req && (!bus.cpu_req || starveHit || burstHold);
    assign cpuGnt    = !reset && bus.cpu_req && !dmaGnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_CPU;
            waitCnt        <= 4'd0;
            burstCnt       <= 4'd0;
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= 32'h0;
        end else begin
            state          <= stateNext;
            waitCnt        <= waitCntNext;
            burstCnt       <= burstCntNext;
            bus.dma_rvalid <= dmaGnt && !bus.dma_we;
            if (dmaGnt && !bus.dma_we) begin
                bus.dma_rdata <= bus.M_dataOUT;
            end
        end
    end

    // Next-state logic
    always_comb begin
        stateNext    = S_CPU;
        burstCntNext = 4'd0;
        waitCntNext  = 4'd0;

        // A denied request ages toward a forced grant; any grant or idle resets it.
        if (bus.dma_req && !dmaGnt) begin
            waitCntNext = (waitCnt == STARVE_LIM) ? waitCnt : waitCnt + 4'd1;
        end

        case (state)
            S_CPU: begin
                if (dmaGnt && bus.dma_lock) begin
                    stateNext    = S_DMA_LOCK;
                    burstCntNext = 4'd1;
                end
            end
            S_DMA_LOCK: begin
                if (dmaGnt && bus.dma_lock && (burstCnt < BURST_LIM)) begin
                    stateNext    = S_DMA_LOCK;
                    burstCntNext = burstCnt + 4'd1;
                end
            end
            default: begin
                stateNext    = S_CPU;
                burstCntNext = 4'd0;
            end
        endcase
    end

    // Outputs: grant/stall and memory mux; unselected memory inputs are driven to zero.
    always_comb begin
        bus.dma_gnt        = dmaGnt;
        bus.cpu_stall      = !reset && bus.cpu_req && dmaGnt;
        bus.cpu_rdata      = bus.M_dataOUT;
        bus.DM_writeMem_EN = 1'b0;
        bus.DM_ADDR        = 32'h0;
        bus.DM_dataIN      = 32'h0;
        bus.M_isByte       = 1'b0;
        bus.M_PC           = 32'h0;
        if (dmaGnt) begin
            bus.DM_writeMem_EN = bus.dma_we;
            bus.DM_ADDR        = bus.dma_addr;
            bus.DM_dataIN      = bus.dma_wdata;
            bus.M_PC           = DMA_PC_TAG;
        end else if (cpuGnt) begin
            bus.DM_writeMem_EN = bus.cpu_we;
            bus.DM_ADDR        = bus.cpu_addr;
            bus.DM_dataIN      = bus.cpu_wdata;
            bus.M_isByte       = bus.cpu_byte;
            bus.M_PC           = bus.cpu_pc;
        end
    end
endmodule

// File: doc/dm_access_arbiter.md
# dm_access_arbiter

Single-port arbiter and sequencer that shares the data memory between the pipeline's M stage and a DMA/debug requester. The data memory allows one access per cycle, with combinational reads and writes on the clock edge. This block sits between those two requesters and the memory. It selects one requester per cycle and drives the memory's write enable, address, data, byte-select and PC-tag inputs. It stalls the CPU when the DMA wins, and it returns registered read data to the DMA.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied DMA cycles before the DMA is forced a grant; legal range 1..15.
- BURST_MAX, 8: maximum consecutive DMA grants in one locked burst; legal range 1..15.
- DMA_PC_TAG, 32'h0000_0000: value driven on M_PC during DMA accesses.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  M-stage access valid.
- cpu_we  in  1  M-stage store.
- cpu_byte  in  1  M-stage byte access (sb/lb).
- cpu_addr  in  32  M-stage byte address.
- cpu_wdata  in  32  M-stage store data.
- cpu_pc  in  32  M-stage PC, used for the memory trace.
- cpu_rdata  out  32  M_dataOUT, passed through combinationally.
- cpu_stall  out  1  freezes the pipeline this cycle.
- dma_req  in  1  DMA access valid.
- dma_we  in  1  DMA write.
- dma_lock  in  1  requests that the DMA keep ownership on the following cycles (burst).
- dma_addr  in  32  DMA byte address; accesses are always word.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  registered; high the cycle after a granted DMA read.
- dma_rdata  out  32  registered read data.
- DM_writeMem_EN  out  1  to memory.
- DM_ADDR  out  32  to memory.
- DM_dataIN  out  32  to memory.
- M_isByte  out  1  to memory.
- M_PC  out  32  to memory.
- M_dataOUT  in  32  from memory.

## Operation
State machine states:
- S_CPU: default state; the CPU has priority.
- S_DMA_LOCK: the DMA owns the memory for a burst.

Registered state:
- wait_cnt: 4 bits.
- burst_cnt: 4 bits.
- dma_rvalid and dma_rdata.

Grant rule (combinational from state and requests):
- starve_hit = (wait_cnt == STARVE_LIMIT).
- burst_hold = (state == S_DMA_LOCK) && dma_lock && (burst_cnt < BURST_MAX).
- dma_gnt = !reset && dma_req && (!cpu_req || starve_hit || burst_hold).
- cpu_gnt = !reset && cpu_req && !dma_gnt.
- cpu_stall = !reset && cpu_req && dma_gnt.

Memory mux:
- cpu_gnt: memory inputs come from the cpu_* signals; M_PC = cpu_pc.
- dma_gnt: memory inputs come from the dma_* signals; M_isByte = 0; M_PC = DMA_PC_TAG.
- Neither granted: DM_writeMem_EN = 0, and all other memory outputs are 0.
- DM_writeMem_EN = (cpu_gnt && cpu_we) || (dma_gnt && dma_we).
- cpu_rdata = M_dataOUT at all times. It is meaningful only when cpu_gnt is high.

wait_cnt:
- Increments, saturating at STARVE_LIMIT, when dma_req && !dma_gnt.
- Clears to 0 when dma_gnt is high or dma_req is low.

State transitions:
- S_CPU -> S_DMA_LOCK when dma_gnt && dma_lock. burst_cnt is set to 1.
- S_DMA_LOCK stays in S_DMA_LOCK while dma_gnt && dma_lock && (burst_cnt < BURST_MAX). burst_cnt increments.
- S_DMA_LOCK -> S_CPU otherwise. burst_cnt clears to 0.
- Reaching BURST_MAX forces a return to S_CPU. Because wait_cnt was cleared during the burst, the CPU wins the next cycle whenever both request.

DMA read return:
- On dma_gnt && !dma_we: dma_rdata <= M_dataOUT, and dma_rvalid <= 1 on the next cycle.
- Otherwise dma_rvalid <= 0 and dma_rdata holds its value.

Boundary cases:
- Simultaneous requests, no starvation, not locked: the CPU wins.
- dma_lock with no dma_req: ignored, no transition.
- Address alignment: the DMA drives a word address. The arbiter does not check or modify dma_addr[1:0]; they are passed straight to DM_ADDR.

## Timing
- Grant, stall and memory-mux outputs are combinational within the same cycle. A memory write commits on the edge ending the granted cycle.
- DMA read latency: 1 cycle from grant to dma_rvalid.
- cpu_stall latency: 0 cycles.
- A stalled CPU must hold its request unchanged. The arbiter does not buffer CPU requests.
- Reset values: state = S_CPU; wait_cnt = 0; burst_cnt = 0; dma_rvalid = 0; dma_rdata = 0.
- While reset is high: all grants = 0, cpu_stall = 0, DM_writeMem_EN = 0.
- Reset mid-burst: the burst is abandoned. Next cycle the block is in S_CPU with counters at 0 and no pending dma_rvalid.
- Worst-case CPU stall: BURST_MAX consecutive cycles.
- Worst-case DMA wait: STARVE_LIMIT cycles, after which it is granted on the next cycle.

## Test plan
- Reset: assert reset for 2 cycles with cpu_req = 1, cpu_we = 1 and dma_req = 1 -> DM_writeMem_EN = 0, cpu_stall = 0, dma_gnt = 0, dma_rvalid = 0 throughout.
- CPU only: sb to addr 0x0000_0001 with data 0x0000_AB00, then lb from 0x1 -> M_isByte = 1, M_PC = cpu_pc, cpu_rdata = 0x0000_00AB, cpu_stall never high.
- Starvation: STARVE_LIMIT = 4; cpu_req and dma_req held high (DMA read at 0x40) -> dma_gnt in cycle 5 only, cpu_stall in cycle 5 only, dma_rvalid in cycle 6 with the stored word.
- Burst cap: BURST_MAX = 8; dma_req = dma_lock = 1 with cpu_req = 1 and STARVE_LIMIT = 1 -> after the 1-cycle starvation wait, 8 consecutive dma_gnt with cpu_stall high, then 1 cycle of cpu_gnt; the pattern then repeats.
- DMA idle-CPU write: cpu_req = 0; DMA writes 0x1234_5678 to 0x80 then reads 0x80 -> M_PC = DMA_PC_TAG, M_isByte = 0, dma_rdata = 0x1234_5678 with dma_rvalid one cycle after the read grant.
- Reset mid-burst: assert reset during the 3rd burst cycle -> state returns to S_CPU, and the first post-reset simultaneous request goes to the CPU.
